// File: rtl/tlight_v2.sv
// tlight_v2: two-way traffic-light Moore FSM (clock, async reset -> ns/we light controls)
package tlight_package;
  typedef enum logic [1:0] {RED, YELLOW, GREEN} tlight_control_t;
endpackage

module tlight_v2
  import tlight_package::*;
#(
  parameter int READY_TIME = 3,
  parameter int GO_TIME    = 15,
  parameter int STOP_TIME  = 1
) (
  input  logic            clock,
  input  logic            reset,
  output tlight_control_t ns,
  output tlight_control_t we
);
  typedef enum logic [2:0] {
    RESET, WE_READY_TO_GO, WE_GO, WE_PREPARE_TO_STOP, NS_READY_TO_GO, NS_GO, NS_PREPARE_TO_STOP
  } state_t;
  state_t     state, state_d;
  logic [3:0] timer, timer_d;
  always_comb begin
    case (state)
      RESET:              state_d = WE_READY_TO_GO;
      WE_READY_TO_GO:     state_d = WE_GO;
      WE_GO:              state_d = WE_PREPARE_TO_STOP;
      WE_PREPARE_TO_STOP: state_d = NS_READY_TO_GO;
      NS_READY_TO_GO:     state_d = NS_GO;
      NS_GO:              state_d = NS_PREPARE_TO_STOP;
      NS_PREPARE_TO_STOP: state_d = WE_READY_TO_GO;
      default:            state_d = RESET;
    endcase
  end
  always_comb begin
    timer_d = (state_d == WE_READY_TO_GO || state_d == NS_READY_TO_GO) ? 4'(READY_TIME - 1) :
              (state_d == WE_GO || state_d == NS_GO) ? 4'(GO_TIME - 1) :
              (state_d == WE_PREPARE_TO_STOP || state_d == NS_PREPARE_TO_STOP) ? 4'(STOP_TIME - 1) : 4'd0;
  end
  // an illegal encoding maps to RESET and leaves at once instead of waiting out its timer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RESET;
      timer <= 4'd0;
    end else if (timer == 4'd0 || state_d == RESET) begin
      state <= state_d;
      timer <= timer_d;
    end else begin
      timer <= timer - 4'd1;
    end
  end
  always_comb begin
    ns = (state == NS_GO) ? GREEN :
         (state == NS_READY_TO_GO || state == NS_PREPARE_TO_STOP) ? YELLOW : RED;
    we = (state == WE_GO) ? GREEN :
         (state == WE_READY_TO_GO || state == WE_PREPARE_TO_STOP) ? YELLOW : RED;
  end
endmodule

// File: tb/tb_tlight_v2.sv
// tb_tlight_v2: table, directed and randomized checks of tlight_v2 against a cycle-count model
module tb_tlight_v2;
  import tlight_package::*;
  localparam int RT = 3, GT = 15, ST = 1;
  localparam int PER = 2 * (RT + GT + ST);
  typedef struct {
    int              edges;
    int              st;
    tlight_control_t ns;
    tlight_control_t we;
  } vec_t;
  logic            clock = 1'b0;
  logic            reset = 1'b1;
  tlight_control_t ns, we;
  int              errors = 0, checks = 0;
  int              t = 0;
  vec_t            vecs[14];
  int              dur[6];
  tlight_control_t lut_ns[7], lut_we[7];

  tlight_v2 #(.READY_TIME(RT), .GO_TIME(GT), .STOP_TIME(ST)) dut (
    .clock(clock), .reset(reset), .ns(ns), .we(we)
  );

  always #5 clock = ~clock;

  // t = rising edges seen with reset low since the last reset; phase found by walking durations
  function automatic void model(input int edges, output int st, output int tm);
    int p;
    st = 0;
    tm = 0;
    if (edges > 0) begin
      p = (edges - 1) % PER;
      for (int i = 0; i < 6; i++) begin
        if (st == 0 && p < dur[i]) begin
          st = i + 1;
          tm = dur[i] - 1 - p;
        end else if (st == 0) p -= dur[i];
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0d want %0d", name, t, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int st, tm;
    model(t, st, tm);
    chk({tag, ".state"}, int'(dut.state), st);
    chk({tag, ".timer"}, int'(dut.timer), tm);
    chk({tag, ".ns"}, int'(ns), int'(lut_ns[st]));
    chk({tag, ".we"}, int'(we), int'(lut_we[st]));
    chk({tag, ".safety"}, int'(ns != RED && we != RED), 0);
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) t++;
    #2;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    t = 0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    int st, tm;
    dur = '{RT, GT, ST, RT, GT, ST};
    lut_ns = '{RED, RED, RED, RED, YELLOW, GREEN, YELLOW};
    lut_we = '{RED, YELLOW, GREEN, YELLOW, RED, RED, RED};
    vecs = '{
      '{0, 0, RED, RED},    '{1, 1, RED, YELLOW},  '{3, 1, RED, YELLOW},  '{4, 2, RED, GREEN},
      '{18, 2, RED, GREEN}, '{19, 3, RED, YELLOW}, '{20, 4, YELLOW, RED}, '{22, 4, YELLOW, RED},
      '{23, 5, GREEN, RED}, '{37, 5, GREEN, RED},  '{38, 6, YELLOW, RED}, '{39, 1, RED, YELLOW},
      '{76, 6, YELLOW, RED}, '{77, 1, RED, YELLOW}
    };
    #2;
    do_reset(2);
    check_all("release");
    tick();
    check_all("first_edge");
    foreach (vecs[i]) begin
      do_reset(1);
      repeat (vecs[i].edges) tick();
      chk($sformatf("vec%0d.state", i), int'(dut.state), vecs[i].st);
      chk($sformatf("vec%0d.ns", i), int'(ns), int'(vecs[i].ns));
      chk($sformatf("vec%0d.we", i), int'(we), int'(vecs[i].we));
      model(t, st, tm);
      chk($sformatf("vec%0d.timer", i), int'(dut.timer), tm);
    end
    do_reset(1);
    repeat (10) tick();
    check_all("mid_go");
    #1;
    reset = 1'b1;
    t = 0;
    #1;
    check_all("async_rst");
    repeat (3) begin
      tick();
      check_all("held_rst");
    end
    reset = 1'b0;
    check_all("rerelease");
    for (int c = 0; c < 100; c++) begin
      tick();
      check_all("run");
    end
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 3) begin
        #($urandom_range(1, 6));
        reset = 1'b1;
        t = 0;
        #1;
        check_all("rnd_rst");
        repeat ($urandom_range(1, 3)) tick();
        reset = 1'b0;
      end
      tick();
      check_all("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
